ap_mem_model_dp: RTL

- Parametrised dual-port simulation and emulation memory model for HLS ap_memory array arguments of the MSM kernel (point coordinates, scalars, bucket indices).
- Generalises the fixed 1-cycle test-vector RAM with:
  - configurable width, depth and read latency;
  - ce-gated reads and a selectable read-during-write mode;
  - a handshaked host load port, so testcases stream in without file preload;
  - collision and out-of-range error monitoring.
- One instance per kernel array.

---
 rtl/ap_mem_model_dp.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ap_mem_model_dp.sv
// Dual-port ap_memory array model with configurable read latency, host load port
// and collision / out-of-range monitoring. Contents are not cleared by reset.
module ap_mem_model_dp #(
    parameter int DATA_WIDTH   = 377,
    parameter int ADDR_WIDTH   = 4,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE   = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic                  ce0,
    input  logic                  we0,
    input  logic [DATA_WIDTH-1:0] d0,
    output logic [DATA_WIDTH-1:0] q0,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic                  ce1,
    input  logic                  we1,
    input  logic [DATA_WIDTH-1:0] d1,
    output logic [DATA_WIDTH-1:0] q1,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  err_clr,
    output logic [15:0]           collision_cnt,
    output logic                  err_oob
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] rd_pipe_q [2][READ_LATENCY];
    logic                  rd_vld_q  [2][READ_LATENCY];
    logic [15:0]           coll_cnt_q, coll_cnt_d;
    logic                  err_oob_q, err_oob_d;

    logic [DATA_WIDTH-1:0] rdata [2];
    logic                  issue [2];
    logic                  wr0, wr1, ld_acc, ld_ok, coll, viol;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    assign ld_ready = !ap_rst && !ce0 && !ce1;
    assign ld_acc   = ld_valid && ld_ready;
    assign ld_ok    = ld_acc && in_range(ld_addr);
    assign wr0      = ce0 && we0 && in_range(address0);
    assign wr1      = ce1 && we1 && in_range(address1);

    // Read data is sampled before this edge's writes land, so a cross-port read sees old data.
    always_comb begin
        issue[0] = ce0;
        issue[1] = ce1;
        rdata[0] = '0;
        rdata[1] = '0;
        if (ce0 && in_range(address0))
            rdata[0] = (we0 && WRITE_MODE == 1) ? d0 : mem[address0];
        if (ce1 && in_range(address1))
            rdata[1] = (we1 && WRITE_MODE == 1) ? d1 : mem[address1];
    end

    assign coll = ce0 && ce1 && (address0 == address1) && in_range(address0) && (we0 || we1);
    assign viol = (ce0 && !in_range(address0)) || (ce1 && !in_range(address1)) ||
                  (ld_acc && !in_range(ld_addr));

    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (coll && coll_cnt_q != 16'hFFFF)
            coll_cnt_d = coll_cnt_q + 16'd1;
        err_oob_d = err_oob_q;
        if (viol)
            err_oob_d = 1'b1;
        else if (err_clr)
            err_oob_d = 1'b0;
    end

    // Port 1 is applied after port 0 so it wins a same-address double write.
    always_ff @(posedge ap_clk) begin
        if (wr0)
            mem[address0] <= d0;
        if (wr1)
            mem[address1] <= d1;
        if (ld_ok)
            mem[ld_addr] <= ld_data;
    end

    // Each stage only loads when its predecessor carries a read, so the last stage holds q.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < READ_LATENCY; i++) begin
                    rd_pipe_q[p][i] <= '0;
                    rd_vld_q[p][i]  <= 1'b0;
                end
            end
            coll_cnt_q <= '0;
            err_oob_q  <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rd_vld_q[p][0] <= issue[p];
                if (issue[p])
                    rd_pipe_q[p][0] <= rdata[p];
                for (int i = 1; i < READ_LATENCY; i++) begin
                    rd_vld_q[p][i] <= rd_vld_q[p][i-1];
                    if (rd_vld_q[p][i-1])
                        rd_pipe_q[p][i] <= rd_pipe_q[p][i-1];
                end
            end
            coll_cnt_q <= coll_cnt_d;
            err_oob_q  <= err_oob_d;
        end
    end

    assign q0            = rd_pipe_q[0][READ_LATENCY-1];
    assign q1            = rd_pipe_q[1][READ_LATENCY-1];
    assign collision_cnt = coll_cnt_q;
    assign err_oob       = err_oob_q;

endmodule
